// File: rtl/edge_wr_pkg.sv
// Shared constants, entry type and sizing helper for the edge SRAM writer.
package edge_wr_pkg;

    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned WORD_W       = 16;
    localparam int unsigned PIX_W        = WORD_W / PIX_PER_WORD;
    localparam int unsigned LANE_W       = $clog2(PIX_PER_WORD);
    // Widest SRAM word address the entry type can carry.
    localparam int unsigned IDX_MAX_W    = 32;

    // Write entry: word index within the frame plus packed pixel data.
    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic [WORD_W-1:0]    data;
    } wr_entry_t;

    // Number of packed words in one frame.
    function automatic int unsigned words_per_frame(input int unsigned w, input int unsigned h);
        return (w * h) / PIX_PER_WORD;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a fall-through head; push while full is only
// accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/edge_sram_writer.sv
// Packs 4-bit edge pixels four per 16-bit word and writes them to SRAM
// through a small FIFO with a we/ack handshake, tracking frame position.
// Optional macro EDGE_THRESH_EN: binarize each pixel against thresh.
// ADDR_W must not exceed edge_wr_pkg::IDX_MAX_W.
module edge_sram_writer
    import edge_wr_pkg::*;
#(
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic              in_valid,
    input  logic              sync_clear,
    input  logic [PIX_W-1:0]  thresh,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic              sram_ack,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned WORDS  = words_per_frame(IMG_W, IMG_H);
    localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned ENT_W  = ADDR_W + WORD_W;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_WORD - 1);

    logic [LANE_W-1:0]                  lane_q, lane_d, lane_eff;
    logic [PIX_PER_WORD-1:0][PIX_W-1:0] word_q, word_d, word_eff;
    logic [WIDX_W-1:0]                  widx_q, widx_d, widx_eff;
    logic [PIX_W-1:0]                   pix_c;
    logic                               push_req;
    logic [ENT_W-1:0]                   push_data;
    logic [ENT_W-1:0]                   head_data;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic                               pop;
    logic                               drop;
    wr_entry_t                          head_ent;
    logic                               frame_done_q, frame_done_d;
    logic                               overflow_q;

`ifdef EDGE_THRESH_EN
    // Binarize the incoming pixel against the threshold.
    assign pix_c = (pixel_in >= thresh) ? {PIX_W{1'b1}} : '0;
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign pix_c         = pixel_in;
`endif

    // Packer next state: sync_clear restarts the word/frame before this cycle's pixel lands.
    always_comb begin
        lane_eff  = sync_clear ? '0 : lane_q;
        word_eff  = sync_clear ? '0 : word_q;
        widx_eff  = sync_clear ? '0 : widx_q;
        lane_d    = lane_eff;
        word_d    = word_eff;
        widx_d    = widx_eff;
        push_req  = 1'b0;
        push_data = {ADDR_W'(widx_eff), word_eff};
        if (in_valid) begin
            word_d[lane_eff] = pix_c;
            if (lane_eff == LANE_LAST) begin
                push_req  = 1'b1;
                push_data = {ADDR_W'(widx_eff), word_d};
                lane_d    = '0;
                word_d    = '0;
                widx_d    = (widx_eff == WIDX_W'(WORDS - 1)) ? '0 : widx_eff + WIDX_W'(1);
            end else begin
                lane_d = lane_eff + LANE_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_req),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head_data)
    );

    // Unpack the FIFO head into an entry view.
    always_comb begin
        head_ent      = '0;
        head_ent.idx  = IDX_MAX_W'(head_data[WORD_W +: ADDR_W]);
        head_ent.data = head_data[WORD_W-1:0];
    end

    assign pop  = !fifo_empty && sram_ack;
    assign drop = push_req && fifo_full && !pop;

    // Last word of the frame retired, either written or lost to a full FIFO.
    always_comb begin
        frame_done_d = (pop && (head_ent.idx == IDX_MAX_W'(WORDS - 1))) ||
                       (drop && (widx_eff == WIDX_W'(WORDS - 1)));
    end

    // Packer, frame pulse and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q       <= '0;
            word_q       <= '0;
            widx_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            word_q       <= word_d;
            widx_q       <= widx_d;
            frame_done_q <= frame_done_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign sram_we    = !fifo_empty;
    assign sram_addr  = ADDR_W'(IDX_MAX_W'(BASE_ADDR) + head_ent.idx);
    assign sram_wdata = head_ent.data;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_edge_sram_writer.sv
// Directed bench for edge_sram_writer on a reduced 16x4 frame (16 words).
module tb_edge_sram_writer;

    localparam int unsigned IMG_W = 16;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 18;
    localparam int unsigned BASE  = 0;
    localparam int          WORDS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    pixel_in;
    logic          in_valid;
    logic          sync_clear;
    logic [3:0]    thresh;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata;
    logic          sram_ack;
    logic          frame_done;
    logic          overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    edge_sram_writer #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pixel_in),
        .in_valid   (in_valid),
        .sync_clear (sync_clear),
        .thresh     (thresh),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_ack   (sram_ack),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct {
        logic        sc;
        logic        vld;
        logic [3:0]  pix;
        logic        ack;
        logic        we;
        logic [17:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sc, input logic vld, input logic [3:0] pix,
                                input logic ack, input logic we, input logic [17:0] addr,
                                input logic [15:0] data);
        vec_t v;
        v.sc = sc; v.vld = vld; v.pix = pix; v.ack = ack;
        v.we = we; v.addr = addr; v.data = data;
        return v;
    endfunction

    // Expected stored word for a raw packed word (binarized when the option is built in).
    function automatic logic [15:0] thr_word(input logic [15:0] w);
        logic [15:0] r;
        r = w;
`ifdef EDGE_THRESH_EN
        for (int k = 0; k < 4; k++) begin
            r[k*4 +: 4] = (w[k*4 +: 4] >= thresh) ? 4'hF : 4'h0;
        end
`endif
        return r;
    endfunction

    function automatic logic [3:0] pixf(input int i);
        return 4'(i * 5 + 1);
    endfunction

    function automatic logic [15:0] word_model(input int w);
        return {pixf(4*w+3), pixf(4*w+2), pixf(4*w+1), pixf(4*w)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sc, input logic vld, input logic [3:0] p, input logic a);
        sync_clear = sc;
        in_valid   = vld;
        pixel_in   = p;
        sram_ack   = a;
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_we"},    32'(sram_we),    32'd0);
        chk({tag, "_rst_addr"},  32'(sram_addr),  32'(BASE));
        chk({tag, "_rst_wdata"}, 32'(sram_wdata), 32'd0);
        chk({tag, "_rst_fd"},    32'(frame_done), 32'd0);
        chk({tag, "_rst_ovf"},   32'(overflow),   32'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int wr;
        int fd_cnt;
        int fd_at;
        int last_addr;

        rst    = 1'b1;
        thresh = 4'd8;
        drive(1'b0, 1'b0, 4'h0, 1'b0);

        // ---------------- table-driven vectors ----------------
        vecs.push_back(mk(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 18'd0, 16'h4321));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 18'd1, 16'h8765));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 18'd1, 16'h8765));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 18'd0, 16'h0000));
        // partial word A,B then sync_clear, then A,B,C,D -> word 0
        vecs.push_back(mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'hD, 1'b0, 1'b1, 18'd0, 16'hDCBA));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 18'd0, 16'h0000));
        // sync_clear together with in_valid: that pixel becomes lane 0 of word 0
        vecs.push_back(mk(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 18'd0, 16'h4321));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 18'd0, 16'h0000));
        // threshold pattern 7,8,9,0 (binarized to 0FF0 when the option is built in)
        vecs.push_back(mk(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 18'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 18'd1, 16'h0987));
        vecs.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 18'd0, 16'h0000));

        do_reset("t0");
        foreach (vecs[k]) begin
            drive(vecs[k].sc, vecs[k].vld, vecs[k].pix, vecs[k].ack);
            tick();
            chk($sformatf("vec%0d_we", k), 32'(sram_we), 32'(vecs[k].we));
            if (vecs[k].we) begin
                chk($sformatf("vec%0d_addr", k), 32'(sram_addr), 32'(vecs[k].addr));
                chk($sformatf("vec%0d_data", k), 32'(sram_wdata), 32'(thr_word(vecs[k].data)));
            end
            chk($sformatf("vec%0d_ovf", k), 32'(overflow), 32'd0);
            chk($sformatf("vec%0d_fd", k), 32'(frame_done), 32'd0);
        end

        // ---------------- held request, then back-to-back writes ----------------
        do_reset("t1");
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 4'(i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold%0d_we", c), 32'(sram_we), 32'd1);
            chk($sformatf("hold%0d_addr", c), 32'(sram_addr), 32'd0);
            chk($sformatf("hold%0d_data", c), 32'(sram_wdata), 32'(thr_word(16'h4321)));
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        tick();
        chk("b2b_we", 32'(sram_we), 32'd1);
        chk("b2b_addr", 32'(sram_addr), 32'd1);
        chk("b2b_data", 32'(sram_wdata), 32'(thr_word(16'h8765)));
        tick();
        chk("b2b_empty_we", 32'(sram_we), 32'd0);

        // ---------------- asynchronous reset abandons a pending write ----------------
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 4'(i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        chk("pend_we", 32'(sram_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we", 32'(sram_we), 32'd0);
        chk("async_rst_addr", 32'(sram_addr), 32'(BASE));
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_we", 32'(sram_we), 32'd0);

        // ---------------- ack held low for a whole frame: overflow ----------------
        do_reset("t2");
        fd_cnt = 0;
        fd_at  = -1;
        for (int i = 0; i < 4 * WORDS; i++) begin
            drive(1'b0, 1'b1, pixf(i), 1'b0);
            tick();
            if (i == 31) chk("ovf_before_drop", 32'(overflow), 32'd0);
            if (i == 35) chk("ovf_after_drop", 32'(overflow), 32'd1);
            if (frame_done) begin
                fd_cnt++;
                fd_at = i;
            end
        end
        chk("ovf_fd_count", 32'(fd_cnt), 32'd1);
        chk("ovf_fd_at_drop", 32'(fd_at), 32'(4 * WORDS - 1));
        drive(1'b1, 1'b0, 4'h0, 1'b0);
        tick();
        chk("ovf_sticky_sc", 32'(overflow), 32'd1);
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        for (int w = 0; w < int'(DEPTH); w++) begin
            chk($sformatf("drain%0d_we", w), 32'(sram_we), 32'd1);
            chk($sformatf("drain%0d_addr", w), 32'(sram_addr), 32'(w));
            chk($sformatf("drain%0d_data", w), 32'(sram_wdata), 32'(thr_word(word_model(w))));
            tick();
        end
        chk("drain_empty_we", 32'(sram_we), 32'd0);
        chk("ovf_still_set", 32'(overflow), 32'd1);

        // ---------------- full frame with ack high: wrap and frame_done ----------------
        do_reset("t3");
        wr        = 0;
        fd_cnt    = 0;
        last_addr = -1;
        for (int i = 0; i < 4 * WORDS; i++) begin
            drive(1'b0, 1'b1, pixf(i), 1'b1);
            tick();
            if (sram_we) begin
                chk($sformatf("frm_w%0d_addr", wr), 32'(sram_addr), 32'(wr));
                chk($sformatf("frm_w%0d_data", wr), 32'(sram_wdata), 32'(thr_word(word_model(wr))));
                last_addr = int'(sram_addr);
                wr++;
            end
            if (frame_done) fd_cnt++;
        end
        chk("frm_writes", 32'(wr), 32'(WORDS));
        chk("frm_last_addr", 32'(last_addr), 32'(WORDS - 1));
        chk("frm_fd_early", 32'(fd_cnt), 32'd0);
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        tick();
        chk("frm_fd_pulse", 32'(frame_done), 32'd1);
        chk("frm_empty_we", 32'(sram_we), 32'd0);
        tick();
        chk("frm_fd_width", 32'(frame_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, pixf(i), 1'b1);
            tick();
        end
        chk("wrap_we", 32'(sram_we), 32'd1);
        chk("wrap_addr", 32'(sram_addr), 32'd0);
        chk("wrap_data", 32'(sram_wdata), 32'(thr_word(word_model(0))));
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        tick();
        chk("wrap_fd_quiet", 32'(frame_done), 32'd0);
        chk("wrap_empty_we", 32'(sram_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
